// File: rtl/config_source_arbiter.sv
// Two-source configuration arbiter: a UART byte stream and a bitbang word port compete
// for the frame loader's WriteData/WriteStrobe/ComActive interface; first sync wins.
module config_source_arbiter #(
    parameter int          NUM_ROWS       = 6,
    parameter int          DESYNC_FLAG    = 20,
    parameter int          TIMEOUT_CYCLES = 1048576,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [7:0]  uart_byte,
    input  logic        uart_byte_valid,
    input  logic [31:0] bb_word,
    input  logic        bb_word_valid,
    output logic        bb_word_ready,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ComActive,
    output logic        active,
    output logic        owner,
    output logic        timeout_err,
    output logic [7:0]  drop_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(NUM_ROWS + 1);

    typedef enum logic [1:0] {IDLE, GRANT, HDR, DATA} state_t;

    state_t        state_q, state_d;
    // Only the low three bytes of the 32-bit window need storage; the newest byte
    // always comes straight from the input.
    logic [23:0]   sr_q, sr_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic          owner_q, owner_d;
    logic          com_q, com_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wstb_q, wstb_d;
    logic          terr_q, terr_d;
    logic [7:0]    drop_q, drop_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [FW-1:0] frm_q, frm_d;

    logic          busy, bb_own, in_frame, bb_take;
    logic [31:0]   sr_shift, own_w;
    logic          uart_sync, bb_sync, own_v, drop_item, timeout, desync_rel;
    logic [TW-1:0] tcnt_inc;

    assign busy      = (state_q != IDLE);
    assign bb_own    = busy && owner_q;
    assign in_frame  = (state_q == HDR) || (state_q == DATA);
    assign bb_take   = bb_word_valid && (state_q != GRANT);
    assign sr_shift  = {sr_q, uart_byte};
    assign uart_sync = (state_q == IDLE) && uart_byte_valid && (sr_shift == SYNC_WORD);
    assign bb_sync   = (state_q == IDLE) && bb_take && (bb_word == SYNC_WORD);
    assign own_v     = in_frame && (owner_q ? bb_take : (uart_byte_valid && bcnt_q == 2'd3));
    assign own_w     = owner_q ? bb_word : sr_shift;
    // A simultaneous sync loses to UART but its consumed bitbang word still counts.
    assign drop_item = (busy && (owner_q ? uart_byte_valid : bb_take)) || (uart_sync && bb_sync);
    assign tcnt_inc  = tcnt_q + TW'(1);
    assign timeout   = in_frame && !own_v && (tcnt_inc == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bcnt_d     = bcnt_q;
        owner_d    = owner_q;
        wdata_d    = wdata_q;
        wstb_d     = 1'b0;
        terr_d     = terr_q;
        drop_d     = drop_q;
        tcnt_d     = tcnt_q;
        frm_d      = frm_q;
        desync_rel = 1'b0;

        if (uart_byte_valid && !bb_own) begin
            sr_d   = sr_shift[23:0];
            bcnt_d = bcnt_q + 2'd1;
        end
        if (drop_item && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (uart_sync || bb_sync) begin
                    state_d = GRANT;
                    owner_d = !uart_sync;
                    bcnt_d  = 2'd0;
                    tcnt_d  = '0;
                end
            end
            GRANT: begin
                wdata_d = SYNC_WORD;
                wstb_d  = 1'b1;
                state_d = HDR;
            end
            HDR: begin
                if (own_v) begin
                    wdata_d = own_w;
                    wstb_d  = 1'b1;
                    tcnt_d  = '0;
                    if (own_w[DESYNC_FLAG]) begin
                        state_d    = IDLE;
                        desync_rel = 1'b1;
                    end else begin
                        frm_d   = FW'(NUM_ROWS);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (own_v) begin
                    wdata_d = own_w;
                    wstb_d  = 1'b1;
                    tcnt_d  = '0;
                    frm_d   = frm_q - FW'(1);
                    if (frm_q == FW'(1))
                        state_d = HDR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = IDLE;
            terr_d  = 1'b1;
            sr_d    = '0;
            bcnt_d  = 2'd0;
            tcnt_d  = '0;
        end else if (in_frame && !own_v) begin
            tcnt_d = tcnt_inc;
        end

        // The desync header goes out with ComActive still high; it drops a cycle later.
        com_d = (state_d != IDLE) || desync_rel;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcnt_q  <= 2'd0;
            owner_q <= 1'b0;
            com_q   <= 1'b0;
            wdata_q <= '0;
            wstb_q  <= 1'b0;
            terr_q  <= 1'b0;
            drop_q  <= '0;
            tcnt_q  <= '0;
            frm_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            owner_q <= owner_d;
            com_q   <= com_d;
            wdata_q <= wdata_d;
            wstb_q  <= wstb_d;
            terr_q  <= terr_d;
            drop_q  <= drop_d;
            tcnt_q  <= tcnt_d;
            frm_q   <= frm_d;
        end
    end

    assign bb_word_ready = (state_q != GRANT);
    assign WriteData     = wdata_q;
    assign WriteStrobe   = wstb_q;
    assign ComActive     = com_q;
    assign active        = com_q;
    assign owner         = owner_q;
    assign timeout_err   = terr_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Scoreboard bench: expected strobe words are queued as stimulus is driven and
// popped by a negedge monitor whenever WriteStrobe is seen.
module tb_config_source_arbiter;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam logic [31:0] DSYN = 32'h0010_0000;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  uart_byte = '0;
    logic        uart_byte_valid = 1'b0;
    logic [31:0] bb_word = '0;
    logic        bb_word_valid = 1'b0;
    logic        bb_word_ready;
    logic [31:0] WriteData;
    logic        WriteStrobe, ComActive, active, owner, timeout_err;
    logic [7:0]  drop_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    config_source_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .resetn(resetn),
        .uart_byte(uart_byte), .uart_byte_valid(uart_byte_valid),
        .bb_word(bb_word), .bb_word_valid(bb_word_valid), .bb_word_ready(bb_word_ready),
        .WriteData(WriteData), .WriteStrobe(WriteStrobe), .ComActive(ComActive),
        .active(active), .owner(owner), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (WriteStrobe === 1'b1) begin
            chk("strobe_com", {31'b0, ComActive}, 32'd1);
            if (exp_q.size() == 0) chk("unexpected_strobe", exp_q.size(), 32'd1);
            else chk("wdata", WriteData, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        uart_byte = b;
        uart_byte_valid = 1'b1;
        tick();
        uart_byte_valid = 1'b0;
    endtask

    task automatic put_w(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) put_byte(w[8*k +: 8]);
    endtask

    task automatic send_sync_uart();
        put_byte(8'hFA); put_byte(8'hB0); put_byte(8'hFA); put_byte(8'hB1);
    endtask

    task automatic bb_send(input logic [31:0] w);
        logic rdy;
        int tries;
        bb_word = w;
        bb_word_valid = 1'b1;
        rdy = 1'b0;
        tries = 0;
        while (!rdy && tries < 8) begin
            @(negedge CLK);
            rdy = bb_word_ready;
            tick();
            tries++;
        end
        bb_word_valid = 1'b0;
        chk("bb_accept", {31'b0, rdy}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [31:0] w;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_stb", {31'b0, WriteStrobe}, 32'd0);
        chk("rst_com", {31'b0, ComActive}, 32'd0);
        chk("rst_owner", {31'b0, owner}, 32'd0);
        chk("rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
        chk("rst_ready", {31'b0, bb_word_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        // T1: UART sync with a leading junk byte, full frame, then desync header
        put_byte(8'h00); put_byte(8'hFA); put_byte(8'hB0); put_byte(8'hFA);
        chk("t1_com_pre", {31'b0, ComActive}, 32'd0);
        exp_q.push_back(SYNC);
        put_byte(8'hB1);
        chk("t1_com_rise", {31'b0, ComActive}, 32'd1);
        chk("t1_active", {31'b0, active}, 32'd1);
        chk("t1_grant_stb", {31'b0, WriteStrobe}, 32'd0);
        chk("t1_owner", {31'b0, owner}, 32'd0);
        exp_q.push_back(32'h0);
        put_w(32'h0);
        for (int i = 0; i < 6; i++) begin
            w = 32'h1234_5600 + i;
            exp_q.push_back(w);
            put_w(w);
        end
        exp_q.push_back(DSYN);
        put_w(DSYN);
        chk("t1_com_hold", {31'b0, ComActive}, 32'd1);
        tick();
        chk("t1_com_fall", {31'b0, ComActive}, 32'd0);
        chk("t1_qempty", exp_q.size(), 32'd0);

        // T2: bitbang sync followed directly by a desync header
        exp_q.push_back(SYNC);
        exp_q.push_back(DSYN);
        bb_send(SYNC);
        chk("t2_com_rise", {31'b0, ComActive}, 32'd1);
        chk("t2_owner_a", {31'b0, owner}, 32'd1);
        bb_send(DSYN);
        chk("t2_com_hold", {31'b0, ComActive}, 32'd1);
        chk("t2_owner_b", {31'b0, owner}, 32'd1);
        tick();
        chk("t2_com_fall", {31'b0, ComActive}, 32'd0);
        chk("t2_qempty", exp_q.size(), 32'd0);

        // T3: simultaneous sync, UART wins; bitbang flood saturates drop_cnt
        exp_q.push_back(SYNC);
        put_byte(8'hFA); put_byte(8'hB0); put_byte(8'hFA);
        uart_byte = 8'hB1; uart_byte_valid = 1'b1;
        bb_word = SYNC; bb_word_valid = 1'b1;
        tick();
        uart_byte_valid = 1'b0; bb_word_valid = 1'b0;
        chk("t3_com", {31'b0, ComActive}, 32'd1);
        chk("t3_owner", {31'b0, owner}, 32'd0);
        chk("t3_drop1", {24'b0, drop_cnt}, 32'd1);
        for (int i = 0; i < 77; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 300; i++) begin
            uart_byte = 8'h00; uart_byte_valid = 1'b1;
            bb_word = 32'hDEAD_0000 + i; bb_word_valid = 1'b1;
            tick();
            if (i == 99) chk("t3_drop_mid", {24'b0, drop_cnt}, 32'd100);
        end
        uart_byte_valid = 1'b0; bb_word_valid = 1'b0;
        chk("t3_drop_sat", {24'b0, drop_cnt}, 32'd255);
        put_w(32'h0); put_w(32'h0);
        exp_q.push_back(DSYN);
        put_w(DSYN);
        tick();
        chk("t3_com_fall", {31'b0, ComActive}, 32'd0);
        chk("t3_qempty", exp_q.size(), 32'd0);

        // T4: bitbang owner stalls mid-frame and times out
        exp_q.push_back(SYNC);
        bb_send(SYNC);
        exp_q.push_back(32'h0);
        bb_send(32'h0);
        for (int i = 0; i < 3; i++) begin
            w = 32'hC0DE_0000 + i;
            exp_q.push_back(w);
            bb_send(w);
        end
        chk("t4_terr_pre", {31'b0, timeout_err}, 32'd0);
        cnt = 0;
        while (ComActive === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("t4_to_cycles", cnt, 32'd16);
        chk("t4_terr", {31'b0, timeout_err}, 32'd1);
        repeat (3) tick();
        chk("t4_terr_sticky", {31'b0, timeout_err}, 32'd1);
        chk("t4_qempty", exp_q.size(), 32'd0);

        // T5: reset mid-frame, then a clean UART re-sync with a fresh frame count
        exp_q.push_back(SYNC);
        send_sync_uart();
        exp_q.push_back(32'h0);
        put_w(32'h0);
        exp_q.push_back(32'h5555_0001);
        put_w(32'h5555_0001);
        exp_q.push_back(32'h5555_0002);
        put_w(32'h5555_0002);
        put_byte(8'h77);
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_rst_wdata", WriteData, 32'd0);
        chk("t5_rst_stb", {31'b0, WriteStrobe}, 32'd0);
        chk("t5_rst_com", {31'b0, ComActive}, 32'd0);
        chk("t5_rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("t5_rst_drop", {24'b0, drop_cnt}, 32'd0);
        chk("t5_qempty_a", exp_q.size(), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        resetn = 1'b1;
        tick();
        exp_q.push_back(SYNC);
        send_sync_uart();
        chk("t5_com_rise", {31'b0, ComActive}, 32'd1);
        exp_q.push_back(32'h0);
        put_w(32'h0);
        for (int i = 0; i < 6; i++) begin
            w = 32'h6600_0000 + i;
            exp_q.push_back(w);
            put_w(w);
        end
        exp_q.push_back(DSYN);
        put_w(DSYN);
        tick();
        chk("t5_com_fall", {31'b0, ComActive}, 32'd0);
        chk("t5_terr", {31'b0, timeout_err}, 32'd0);
        chk("t5_drop", {24'b0, drop_cnt}, 32'd0);
        chk("t5_qempty_b", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/config_source_arbiter.md
Name: config_source_arbiter

Overview:
- Arbitrates between two configuration sources and drives the shared configuration word interface (WriteData/WriteStrobe/ComActive) of the frame-loading FSM.
- Source 0 is a UART byte stream, packed into 32-bit words. Source 1 is a bitbang 32-bit word port.
- The first source to present the sync word 0xFAB0_FAB1 takes ownership. It keeps ownership until a desync header, timeout or reset.
- Shadows the header/frame word sequence so it knows when the owner may release.

Parameters:
- NUM_ROWS, 6, data words per frame following each header.
- DESYNC_FLAG, 20, header bit index that signals desync.
- TIMEOUT_CYCLES, 1048576, owner idle cycles before forced release; counter width is clog2(TIMEOUT_CYCLES+1).
- SYNC_WORD, 32'hFAB0_FAB1, alignment/sync pattern.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- resetn  in  1  asynchronous, active-low reset.
- uart_byte  in  8  received UART byte.
- uart_byte_valid  in  1  one-cycle strobe qualifying uart_byte; may be asserted every cycle.
- bb_word  in  32  bitbang word.
- bb_word_valid  in  1  bitbang word offered.
- bb_word_ready  out  1  bitbang word accepted when valid&&ready.
- WriteData  out  32  word to the frame-loading FSM.
- WriteStrobe  out  1  one-cycle qualifier for WriteData.
- ComActive  out  1  high while a source owns the port; rising edge resets the frame-loading FSM.
- active  out  1  ownership held (same as ComActive).
- owner  out  1  0 = UART, 1 = bitbang; valid only while active.
- timeout_err  out  1  sticky; set on a timeout release, cleared only by reset.
- drop_cnt  out  8  saturating count of input items rejected while the other source owns the port.

Behaviour:
- Reset (async, resetn=0) clears everything: WriteData=0, WriteStrobe=0, ComActive=0, owner=0, timeout_err=0, drop_cnt=0, packer registers=0, state=IDLE. Asserting reset mid-frame aborts immediately; no further strobes are issued.
- UART packer:
  - Each valid byte shifts into a 32-bit register MSB-first: sr <= {sr[23:0], byte}.
  - Not synced: a word is "complete" only when sr equals SYNC_WORD after the shift (sliding byte alignment).
  - Synced (UART owns the port): a 2-bit byte counter produces one complete word per 4 bytes.
- Bitbang side:
  - bb_word_ready=1 except in the GRANT state.
  - A bitbang word is consumed on valid&&ready.
  - In IDLE only SYNC_WORD is significant; other bitbang words are consumed and discarded without counting.
- States:
  - IDLE: waiting for a sync word from either source.
    - Sync from UART (packer match) or bitbang (consumed word == SYNC_WORD) -> GRANT, with owner latched.
    - If both sources deliver sync in the same cycle, UART wins. The bitbang word is consumed and counted in drop_cnt.
  - GRANT (1 cycle): ComActive rises; WriteStrobe=0.
    - Next cycle: WriteData=SYNC_WORD, WriteStrobe=1 -> HDR.
    - UART bytes arriving in GRANT are packed normally; the byte counter starts at 0 on the grant.
  - HDR: the owner's next complete word is forwarded with 1-cycle latency (WriteData registered, WriteStrobe pulses 1 cycle).
    - If word[DESYNC_FLAG]=1: forward it, then next cycle ComActive=0 -> IDLE.
    - Otherwise load the frame counter with NUM_ROWS -> DATA.
  - DATA: each owner word is forwarded and the counter decrements. When the counter reaches 1 and a word is forwarded -> HDR.
- Non-owner traffic while not IDLE: every bitbang word (ready stays 1) and every UART byte is discarded. drop_cnt increments by 1 per cycle containing any discarded item and saturates at 255.
- Timeout:
  - The counter clears on every forwarded owner word and on grant, and increments each cycle in HDR/DATA.
  - When it reaches TIMEOUT_CYCLES: ComActive=0, timeout_err=1, UART packer cleared, -> IDLE. No strobe is issued.
- WriteStrobe is never asserted in consecutive cycles from GRANT. It is never asserted while ComActive=0, except for the single desync header, which is forwarded while ComActive is still 1.

Test Plan:
- UART bytes 00 FA B0 FA B1, then header 00000000, then 6 words -> ComActive rises the cycle after B1, sync strobe the next cycle, then 7 strobes with matching WriteData; final state HDR.
- Bitbang SYNC_WORD, header with bit 20 set (0x00100000) -> strobes: FAB0FAB1, then 00100000; ComActive falls the cycle after; owner=1 throughout.
- Both sources deliver sync in the same cycle -> owner=0, drop_cnt=1. Subsequent bitbang words are each dropped; drop_cnt increments and saturates at 255 after 300 words.
- Bitbang owner stalls in DATA after 3 words, with TIMEOUT_CYCLES=16 -> ComActive falls 16 cycles after the last strobe, timeout_err=1, no extra strobe.
- resetn pulsed low mid-frame (DATA, counter=4) -> all outputs 0 immediately. Re-sync from UART works and the frame counter restarts at 6.
